bv_match_priority_enc: RTL and testbench

//  Consumes the ANDed rule bit-vector produced by the 4-field BV AND stage and

---
 rtl/bv_match_priority_enc_if.sv | 23 ++
 rtl/bv_match_priority_enc.sv | 164 ++++++++++++++++
 tb/tb_bv_match_priority_enc.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/bv_match_priority_enc_if.sv
// Bundles the rule-vector input and the match-result valid/ready handshake.
// "master" is the side that drives vectors and consumes results; the encoder uses "slave".
interface bv_match_priority_enc_if #(
  parameter int BV_WIDTH  = 64,
  parameter int IDX_WIDTH = 6
);
  logic                 bv_in_valid;
  logic [BV_WIDTH-1:0]  bv_in;
  logic                 match_valid;
  logic                 match_hit;
  logic [IDX_WIDTH-1:0] match_index;
  logic                 match_ready;

  modport master (
    output bv_in_valid, bv_in, match_ready,
    input  match_valid, match_hit, match_index
  );

  modport slave (
    input  bv_in_valid, bv_in, match_ready,
    output match_valid, match_hit, match_index
  );
endinterface

// File: rtl/bv_match_priority_enc.sv
// Two-stage lowest-set-bit priority encoder feeding a show-ahead result FIFO.
// Optional BV_MATCH_STATS_EN adds wrapping hit/miss counters taken at stage 2.
module bv_match_priority_enc #(
  parameter int BV_WIDTH   = 64,
  parameter int IDX_WIDTH  = 6,
  parameter int GRP_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  bv_match_priority_enc_if.slave bus,
  output logic [15:0] drop_cnt,
  output logic        overflow
`ifdef BV_MATCH_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);
  localparam int NUM_GRP = BV_WIDTH / GRP_WIDTH;
  localparam int GIDX_W  = $clog2(GRP_WIDTH);
  localparam int GSEL_W  = IDX_WIDTH - GIDX_W;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENT_W   = IDX_WIDTH + 1;

  // ---------------- stage 1: per-group any / lowest index ----------------
  logic [NUM_GRP-1:0] grp_any_d, grp_any_q;
  logic [GIDX_W-1:0]  grp_idx_d [NUM_GRP];
  logic [GIDX_W-1:0]  grp_idx_q [NUM_GRP];
  logic               s1_valid_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_GRP; gi++) begin : g_grp
      logic [GIDX_W-1:0] low_idx;
      always_comb begin
        low_idx = '0;
        for (int b = GRP_WIDTH - 1; b >= 0; b--) begin
          if (bus.bv_in[gi*GRP_WIDTH + b]) low_idx = GIDX_W'(b);
        end
      end
      assign grp_any_d[gi] = |bus.bv_in[gi*GRP_WIDTH +: GRP_WIDTH];
      assign grp_idx_d[gi] = low_idx;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      grp_any_q  <= '0;
      for (int g = 0; g < NUM_GRP; g++) grp_idx_q[g] <= '0;
    end else begin
      s1_valid_q <= bus.bv_in_valid;
      if (bus.bv_in_valid) begin
        grp_any_q <= grp_any_d;
        for (int g = 0; g < NUM_GRP; g++) grp_idx_q[g] <= grp_idx_d[g];
      end
    end
  end

  // ---------------- stage 2: pick lowest active group ----------------
  logic                 s2_hit_d;
  logic [IDX_WIDTH-1:0] s2_idx_d;
  logic                 s2_valid_q, s2_hit_q;
  logic [IDX_WIDTH-1:0] s2_idx_q;

  always_comb begin
    s2_hit_d = |grp_any_q;
    s2_idx_d = '0;
    for (int g = NUM_GRP - 1; g >= 0; g--) begin
      if (grp_any_q[g]) s2_idx_d = {GSEL_W'(g), grp_idx_q[g]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid_q <= 1'b0;
      s2_hit_q   <= 1'b0;
      s2_idx_q   <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_hit_q <= s2_hit_d;
        s2_idx_q <= s2_idx_d;
      end
    end
  end

  // ---------------- result FIFO with registered show-ahead head ----------------
  logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d, remain;
  logic             head_valid_q, head_valid_d;
  logic [ENT_W-1:0] head_q, head_d;
  logic             pop, full, push, drop;
  logic [15:0]      drop_cnt_q;
  logic             overflow_q;

  always_comb begin
    pop      = head_valid_q & bus.match_ready;
    full     = (count_q == CNT_W'(FIFO_DEPTH));
    push     = s2_valid_q & (~full | pop);
    drop     = s2_valid_q & full & ~pop;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    remain   = count_q - CNT_W'(pop);
    head_valid_d = (count_d != '0);
    // Nothing left behind the popped head: the incoming result bypasses storage.
    if (count_d == '0)     head_d = '0;
    else if (remain == '0) head_d = {s2_hit_q, s2_idx_q};
    else                   head_d = fifo_mem[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {s2_hit_q, s2_idx_q};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_valid_q <= 1'b0;
      head_q       <= '0;
      drop_cnt_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_valid_q <= head_valid_d;
      head_q       <= head_d;
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  assign bus.match_valid = head_valid_q;
  assign bus.match_hit   = head_q[ENT_W-1];
  assign bus.match_index = head_q[IDX_WIDTH-1:0];
  assign drop_cnt        = drop_cnt_q;
  assign overflow        = overflow_q;

`ifdef BV_MATCH_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (s2_valid_q) begin
      if (s2_hit_q) hit_cnt_q  <= hit_cnt_q + 32'd1;
      else          miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_bv_match_priority_enc.sv
// Randomized bench for bv_match_priority_enc against a queue-based behavioural model,
// plus directed scenarios with literal expectations.
module tb_bv_match_priority_enc;
  logic        clk;
  logic        reset;
  logic [15:0] drop_cnt;
  logic        overflow;
`ifdef BV_MATCH_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  bv_match_priority_enc_if #(.BV_WIDTH(64), .IDX_WIDTH(6)) bus ();

  bv_match_priority_enc dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .drop_cnt (drop_cnt),
    .overflow (overflow)
`ifdef BV_MATCH_STATS_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] res;
    int         due;
  } inflight_t;

  inflight_t  inflight[$];
  logic [6:0] fifoq[$];
  int         m_drop;
  bit         m_ovf;
  longint     m_hits, m_misses;
  int         edge_n;
  int         checks;
  int         errors;

  // Expected {hit, index}: lowest set bit, or all zero for an empty vector.
  function automatic logic [6:0] expect_of(input logic [63:0] v);
    for (int i = 0; i < 64; i++) begin
      if (v[i]) return {1'b1, 6'(i)};
    end
    return 7'd0;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    inflight.delete();
    fifoq.delete();
    m_drop   = 0;
    m_ovf    = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  // One clock edge of the model: results arrive two edges after their vector.
  task automatic model_edge(input bit v, input logic [63:0] vec, input bit rdy);
    bit         pop;
    bit         do_push;
    logic [6:0] arr;
    inflight_t  e;
    pop     = (fifoq.size() > 0) && rdy;
    do_push = 1'b0;
    arr     = 7'd0;
    if (inflight.size() > 0 && inflight[0].due == edge_n) begin
      e   = inflight.pop_front();
      arr = e.res;
      if (arr[6]) m_hits++;
      else        m_misses++;
      if (fifoq.size() < 4 || pop) do_push = 1'b1;
      else begin
        if (m_drop < 65535) m_drop++;
        m_ovf = 1'b1;
      end
    end
    if (pop) void'(fifoq.pop_front());
    if (do_push) fifoq.push_back(arr);
    if (v) inflight.push_back('{res: expect_of(vec), due: edge_n + 2});
    edge_n++;
  endtask

  task automatic compare();
    logic [6:0] h;
    h = (fifoq.size() > 0) ? fifoq[0] : 7'd0;
    chk("match_valid", longint'(bus.match_valid), longint'(fifoq.size() > 0));
    chk("match_hit",   longint'(bus.match_hit),   longint'(h[6]));
    chk("match_index", longint'(bus.match_index), longint'(h[5:0]));
    chk("drop_cnt",    longint'(drop_cnt),        longint'(m_drop));
    chk("overflow",    longint'(overflow),        longint'(m_ovf));
`ifdef BV_MATCH_STATS_EN
    chk("hit_cnt",     longint'(hit_cnt),         m_hits & 64'hFFFF_FFFF);
    chk("miss_cnt",    longint'(miss_cnt),        m_misses & 64'hFFFF_FFFF);
`endif
  endtask

  // Called one time unit after a rising edge; drives, steps the model, compares.
  task automatic tick(input bit v, input logic [63:0] vec, input bit rdy);
    bus.bv_in_valid = v;
    bus.bv_in       = vec;
    bus.match_ready = rdy;
    @(posedge clk);
    model_edge(v, vec, rdy);
    #1;
    compare();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    chk("rst_valid", longint'(bus.match_valid), 0);
    chk("rst_hit",   longint'(bus.match_hit),   0);
    chk("rst_index", longint'(bus.match_index), 0);
    chk("rst_drop",  longint'(drop_cnt),        0);
    chk("rst_ovf",   longint'(overflow),        0);
    model_clear();
    bus.bv_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  function automatic logic [63:0] rand_vec();
    logic [63:0] r;
    int          sh;
    sh = $urandom_range(0, 63);
    case ($urandom_range(0, 3))
      0:       r = 64'd0;
      1:       r = 64'd1 << sh;
      2:       r = {$urandom, $urandom};
      default: r = ({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom}) << sh;
    endcase
    return r;
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    edge_n = 0;
    model_clear();
    reset           = 1'b0;
    bus.bv_in_valid = 1'b0;
    bus.bv_in       = '0;
    bus.match_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("init_valid", longint'(bus.match_valid), 0);
    chk("init_index", longint'(bus.match_index), 0);
    chk("init_drop",  longint'(drop_cnt),        0);
    reset = 1'b1;
    tick(0, 64'd0, 1);

    // Single-bit vector: latency 3 to match_valid.
    tick(1, 64'h0000_0000_0000_0001, 1);
    tick(0, 64'd0, 1);
    chk("t1_latency", longint'(bus.match_valid), 0);
    tick(0, 64'd0, 1);
    chk("t1_valid", longint'(bus.match_valid), 1);
    chk("t1_hit",   longint'(bus.match_hit),   1);
    chk("t1_index", longint'(bus.match_index), 0);
    tick(0, 64'd0, 1);

    // Hit then miss back to back.
    tick(1, 64'h0000_0008_0000_0000, 1);
    tick(1, 64'h0, 1);
    tick(0, 64'd0, 1);
    chk("t2_hit_a", longint'(bus.match_hit),   1);
    chk("t2_idx_a", longint'(bus.match_index), 35);
    tick(0, 64'd0, 1);
    chk("t2_valid_b", longint'(bus.match_valid), 1);
    chk("t2_hit_b",   longint'(bus.match_hit),   0);
    chk("t2_idx_b",   longint'(bus.match_index), 0);
    tick(0, 64'd0, 1);

    // Lowest bit wins across groups.
    tick(1, 64'h8000_0000_0001_0000, 1);
    tick(0, 64'd0, 1);
    tick(0, 64'd0, 1);
    chk("t3_idx", longint'(bus.match_index), 16);
    tick(0, 64'd0, 1);

    // Six vectors into a stalled FIFO: four kept, two dropped.
    for (int i = 0; i < 6; i++) tick(1, (64'd1 << (i * 7)) | 64'h8000_0000_0000_0000, 0);
    repeat (3) tick(0, 64'd0, 0);
    chk("t4_drop", longint'(drop_cnt), 2);
    chk("t4_ovf",  longint'(overflow), 1);
    for (int k = 0; k < 4; k++) begin
      chk("t4_order", longint'(bus.match_index), k * 7);
      tick(0, 64'd0, 1);
    end
    chk("t4_empty", longint'(bus.match_valid), 0);

    // Full FIFO with a pop on the arrival edge: no drop.
    for (int i = 0; i < 4; i++) tick(1, 64'd1 << (i + 40), 0);
    repeat (2) tick(0, 64'd0, 0);
    tick(1, 64'h0000_0000_0000_0100, 0);
    tick(0, 64'd0, 0);
    tick(0, 64'd0, 1);
    chk("t5_drop", longint'(drop_cnt), 2);
    chk("t5_idx",  longint'(bus.match_index), 41);
    repeat (6) tick(0, 64'd0, 1);

    // Reset with three results stored and two vectors in flight.
    for (int i = 0; i < 3; i++) tick(1, 64'd1 << (i + 3), 0);
    repeat (2) tick(0, 64'd0, 0);
    tick(1, 64'h10, 0);
    tick(1, 64'h20, 0);
    do_reset();
    repeat (5) tick(0, 64'd0, 1);
    chk("t6_nothing", longint'(bus.match_valid), 0);

    // Randomized traffic with varying downstream pressure.
    for (int c = 0; c < 3000; c++) begin
      bit rdy;
      if ((c / 300) % 2 == 1) rdy = ($urandom_range(0, 9) < 2);
      else                    rdy = ($urandom_range(0, 9) < 7);
      tick(bit'($urandom_range(0, 1)), rand_vec(), rdy);
      if (c == 1700) do_reset();
    end
    repeat (10) tick(0, 64'd0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
